regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU requesters, the register-file write port
// and the decode-stage hazard query.
interface regfile_wb_arbiter_if #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
);
   logic                     alu_valid;
   logic                     alu_ready;
   logic [ADDRESS_WIDTH-1:0] alu_id;
   logic [DATA_WIDTH-1:0]    alu_data;
   logic                     lsu_valid;
   logic                     lsu_ready;
   logic [ADDRESS_WIDTH-1:0] lsu_id;
   logic [DATA_WIDTH-1:0]    lsu_data;
   logic                     write_en;
   logic [ADDRESS_WIDTH-1:0] write_id;
   logic [DATA_WIDTH-1:0]    write_data;
   logic [ADDRESS_WIDTH-1:0] query1_id;
   logic [ADDRESS_WIDTH-1:0] query2_id;
   logic                     hazard1;
   logic                     hazard2;

   modport master (
      output alu_valid, alu_id, alu_data, lsu_valid, lsu_id, lsu_data, query1_id, query2_id,
      input  alu_ready, lsu_ready, write_en, write_id, write_data, hazard1, hazard2
   );

   modport slave (
      input  alu_valid, alu_id, alu_data, lsu_valid, lsu_id, lsu_data, query1_id, query2_id,
      output alu_ready, lsu_ready, write_en, write_id, write_data, hazard1, hazard2
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter: per-requester FIFOs, round-robin
// single write port, and combinational RAW hazard lookup over queued entries.
module regfile_wb_arbiter #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 2
) (
   input logic clk,
   input logic rst,
   regfile_wb_arbiter_if.slave bus
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef logic [ADDRESS_WIDTH-1:0] id_t;
   typedef logic [DATA_WIDTH-1:0]    data_t;
   typedef enum logic {GRANT_ALU = 1'b0, GRANT_LSU = 1'b1} grant_t;

   // Index 0 is the ALU queue, index 1 the LSU queue.
   id_t                   mem_id   [2][FIFO_DEPTH];
   data_t                 mem_data [2][FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] slot_vld [2];
   logic [PW-1:0]         rd_ptr   [2];
   logic [PW-1:0]         wr_ptr   [2];
   logic [CW-1:0]         count    [2];
   id_t                   in_id    [2];
   data_t                 in_data  [2];

   logic [1:0] req_valid, ready, push, pop, nonempty;
   grant_t     grant, last_grant;
   logic       sel;
   id_t        head_id;
   data_t      head_data;
   logic       write_en_q;
   id_t        write_id_q;
   data_t      write_data_q;
   logic       hit1, hit2;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign req_valid  = {bus.lsu_valid, bus.alu_valid};
   assign in_id[0]   = bus.alu_id;
   assign in_id[1]   = bus.lsu_id;
   assign in_data[0] = bus.alu_data;
   assign in_data[1] = bus.lsu_data;

   // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
   always_comb begin
      ready    = '0;
      nonempty = '0;
      for (int q = 0; q < 2; q++) begin
         ready[q]    = (count[q] < CW'(FIFO_DEPTH)) && !rst;
         nonempty[q] = (count[q] != '0);
      end
   end

   assign push          = req_valid & ready;
   assign bus.alu_ready = ready[0];
   assign bus.lsu_ready = ready[1];

   always_comb begin
      grant = GRANT_ALU;
      if (nonempty[0] && nonempty[1]) begin
         grant = (last_grant == GRANT_ALU) ? GRANT_LSU : GRANT_ALU;
      end else if (nonempty[1]) begin
         grant = GRANT_LSU;
      end
   end

   assign sel       = (grant == GRANT_LSU);
   assign pop[0]    = nonempty[0] && !sel;
   assign pop[1]    = nonempty[1] && sel;
   assign head_id   = mem_id[sel][rd_ptr[sel]];
   assign head_data = mem_data[sel][rd_ptr[sel]];

   // NOTE: queue storage carries no reset; slot_vld and count alone decide what is live.
   always_ff @(posedge clk) begin
      for (int q = 0; q < 2; q++) begin
         if (push[q]) begin
            mem_id[q][wr_ptr[q]]   <= in_id[q];
            mem_data[q][wr_ptr[q]] <= in_data[q];
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int q = 0; q < 2; q++) begin
            rd_ptr[q]   <= '0;
            wr_ptr[q]   <= '0;
            count[q]    <= '0;
            slot_vld[q] <= '0;
         end
         last_grant   <= GRANT_LSU;
         write_en_q   <= 1'b0;
         write_id_q   <= '0;
         write_data_q <= '0;
      end else begin
         for (int q = 0; q < 2; q++) begin
            if (push[q]) begin
               wr_ptr[q]               <= next_ptr(wr_ptr[q]);
               slot_vld[q][wr_ptr[q]]  <= 1'b1;
            end
            if (pop[q]) begin
               rd_ptr[q]               <= next_ptr(rd_ptr[q]);
               slot_vld[q][rd_ptr[q]]  <= 1'b0;
            end
            if (push[q] && !pop[q]) begin
               count[q] <= count[q] + 1'b1;
            end else if (pop[q] && !push[q]) begin
               count[q] <= count[q] - 1'b1;
            end
         end
         if (|pop) begin
            last_grant <= grant;
            // Writes to register 0 are dropped but still consume the grant.
            write_en_q <= (head_id != '0);
            if (head_id != '0) begin
               write_id_q   <= head_id;
               write_data_q <= head_data;
            end
         end else begin
            write_en_q <= 1'b0;
         end
      end
   end

   assign bus.write_en   = write_en_q;
   assign bus.write_id   = write_id_q;
   assign bus.write_data = write_data_q;

   // The output register is excluded: the register file forwards same-cycle writes.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int q = 0; q < 2; q++) begin
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (slot_vld[q][k] && (mem_id[q][k] == bus.query1_id)) hit1 = 1'b1;
            if (slot_vld[q][k] && (mem_id[q][k] == bus.query2_id)) hit2 = 1'b1;
         end
      end
   end

   assign bus.hazard1 = hit1 && (bus.query1_id != '0) && !rst;
   assign bus.hazard2 = hit2 && (bus.query2_id != '0) && !rst;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-level reference model predicts
// readiness, hazards and the write stream; a negedge monitor compares.
module tb_regfile_wb_arbiter;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 2;

   typedef struct {
      logic [AW-1:0] id;
      logic [DW-1:0] data;
   } entry_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   regfile_wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int     checks   = 0;
   int     failures = 0;
   entry_t aq[$];
   entry_t lq[$];
   entry_t sb[$];
   entry_t apend[$];
   entry_t lpend[$];
   bit     last_lsu   = 1'b1;
   bit     exp_we     = 1'b0;
   bit     reset_edge = 1'b0;
   bit     started    = 1'b0;
   bit     gate_a     = 1'b1;
   bit     gate_l     = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: two bounded queues, round-robin between them, id 0 discarded.
   always @(posedge clk) begin : model
      entry_t popped;
      bit     a_acc, l_acc, did_pop;
      started = 1'b1;
      if (rst) begin
         aq.delete();
         lq.delete();
         sb.delete();
         last_lsu   = 1'b1;
         exp_we     = 1'b0;
         reset_edge = 1'b1;
      end else begin
         reset_edge = 1'b0;
         a_acc   = (bus.alu_valid === 1'b1) && (aq.size() < DEPTH);
         l_acc   = (bus.lsu_valid === 1'b1) && (lq.size() < DEPTH);
         did_pop = 1'b0;
         if (aq.size() > 0 && (lq.size() == 0 || last_lsu)) begin
            popped   = aq.pop_front();
            last_lsu = 1'b0;
            did_pop  = 1'b1;
         end else if (lq.size() > 0) begin
            popped   = lq.pop_front();
            last_lsu = 1'b1;
            did_pop  = 1'b1;
         end
         if (a_acc) aq.push_back('{bus.alu_id, bus.alu_data});
         if (l_acc) lq.push_back('{bus.lsu_id, bus.lsu_data});
         exp_we = did_pop && (popped.id != 0);
         if (exp_we) sb.push_back(popped);
      end
   end

   always @(negedge clk) begin : monitor
      bit     h1, h2;
      entry_t e;
      if (started) begin
         h1 = 1'b0;
         h2 = 1'b0;
         foreach (aq[i]) begin
            if (aq[i].id == bus.query1_id) h1 = 1'b1;
            if (aq[i].id == bus.query2_id) h2 = 1'b1;
         end
         foreach (lq[i]) begin
            if (lq[i].id == bus.query1_id) h1 = 1'b1;
            if (lq[i].id == bus.query2_id) h2 = 1'b1;
         end
         h1 = h1 && (bus.query1_id != 0) && !rst;
         h2 = h2 && (bus.query2_id != 0) && !rst;
         check("alu_ready", bus.alu_ready, !rst && (aq.size() < DEPTH));
         check("lsu_ready", bus.lsu_ready, !rst && (lq.size() < DEPTH));
         check("hazard1", bus.hazard1, h1);
         check("hazard2", bus.hazard2, h2);
         check("write_en", bus.write_en, exp_we);
         if (reset_edge) begin
            check("reset_write_id", bus.write_id, 0);
            check("reset_write_data", bus.write_data, 0);
         end
         if (bus.write_en === 1'b1) begin
            if (sb.size() == 0) begin
               check("write_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               check("write_id", bus.write_id, e.id);
               check("write_data", bus.write_data, e.data);
            end
         end
      end
   end

   // One cycle of valid/ready handshaking from the pending source queues.
   task automatic step();
      bit a_acc, l_acc;
      bus.alu_valid = (apend.size() > 0) && gate_a;
      bus.lsu_valid = (lpend.size() > 0) && gate_l;
      if (apend.size() > 0) begin
         bus.alu_id   = apend[0].id;
         bus.alu_data = apend[0].data;
      end
      if (lpend.size() > 0) begin
         bus.lsu_id   = lpend[0].id;
         bus.lsu_data = lpend[0].data;
      end
      @(negedge clk);
      a_acc = bus.alu_valid && (bus.alu_ready === 1'b1);
      l_acc = bus.lsu_valid && (bus.lsu_ready === 1'b1);
      @(posedge clk);
      #1;
      if (a_acc) void'(apend.pop_front());
      if (l_acc) void'(lpend.pop_front());
   endtask

   task automatic run(input int tail);
      int n = 0;
      while ((apend.size() > 0 || lpend.size() > 0) && n < 200) begin
         step();
         n++;
      end
      if (apend.size() > 0 || lpend.size() > 0) check("stimulus_timeout", 1, 0);
      repeat (tail) step();
   endtask

   initial begin
      bus.alu_valid = 1'b0;
      bus.lsu_valid = 1'b0;
      bus.alu_id    = '0;
      bus.lsu_id    = '0;
      bus.alu_data  = '0;
      bus.lsu_data  = '0;
      bus.query1_id = '0;
      bus.query2_id = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      step();

      // Single write, fixed latency
      apend.push_back('{5'd5, 32'hDEADBEEF});
      run(4);

      // Both requesters saturated: strict alternation
      apend.push_back('{5'd1, 32'h11}); apend.push_back('{5'd2, 32'h12}); apend.push_back('{5'd3, 32'h13});
      lpend.push_back('{5'd9, 32'h19}); lpend.push_back('{5'd10, 32'h1A}); lpend.push_back('{5'd11, 32'h1B});
      run(5);

      // Deep contention fills the LSU queue; nothing may be lost
      for (int i = 0; i < 6; i++) begin
         apend.push_back('{AW'(i + 1), $urandom});
         lpend.push_back('{AW'(i + 20), $urandom});
      end
      run(6);

      // Register 0 is dropped; the next write still goes out
      bus.query1_id = '0;
      apend.push_back('{5'd0, 32'h1234});
      apend.push_back('{5'd7, 32'h77});
      run(4);

      // Hazard on a queued destination, cleared at the pop edge
      bus.query1_id = 5'd12;
      bus.query2_id = 5'd13;
      apend.push_back('{5'd12, 32'hC0C0});
      run(4);

      // Reset with entries queued in both requesters
      bus.query1_id = 5'd2;
      bus.query2_id = 5'd18;
      for (int i = 0; i < 3; i++) begin
         apend.push_back('{AW'(i + 1), $urandom});
         lpend.push_back('{AW'(i + 17), $urandom});
      end
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      apend.delete();
      lpend.delete();
      apend.push_back('{5'd4, 32'hA4});
      lpend.push_back('{5'd20, 32'hB20});
      run(4);

      // Randomized traffic with gaps and random hazard queries
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 99) < 55 && apend.size() < 4)
            apend.push_back('{($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 15)), $urandom});
         if ($urandom_range(0, 99) < 55 && lpend.size() < 4)
            lpend.push_back('{($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(16, 31)), $urandom});
         gate_a        = ($urandom_range(0, 3) != 0);
         gate_l        = ($urandom_range(0, 3) != 0);
         bus.query1_id = AW'($urandom_range(0, 31));
         bus.query2_id = AW'($urandom_range(0, 31));
         if (c == 300) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end
         step();
      end
      gate_a = 1'b1;
      gate_l = 1'b1;
      run(8);
      check("scoreboard_drained", sb.size(), 0);
      check("model_queues_drained", aq.size() + lq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
